// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronizes N edge inputs, holds one pending event per
// channel and delivers them round-robin over a registered valid/ready port.
module edge_event_arbiter #(
    parameter int N           = 4,
    parameter int TS_W        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in,
    input  logic [N-1:0]         enable,
    input  logic [N-1:0]         mode,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [$clog2(N)-1:0] ev_chan,
    output logic                 ev_edge,
    output logic [TS_W-1:0]      ev_time,
    output logic [7:0]           drop_cnt,
    input  logic                 clr_drop
);
    localparam int CW = $clog2(N);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t          state_q, state_d;
    logic [N-1:0]    sync_q [SYNC_STAGES];
    logic [N-1:0]    sync_d [SYNC_STAGES];
    logic [N-1:0]    prev_q, s, rise, fall, evt;
    logic [N-1:0]    pend_q, pend_d, pend_edge_q, pend_edge_d;
    logic [N-1:0]    take_mask, free, drop;
    logic [TS_W-1:0] pend_time_q [N];
    logic [TS_W-1:0] pend_time_d [N];
    logic [TS_W-1:0] ts_q, ts_d, time_q, time_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [8:0]      sum;
    logic [CW-1:0]   last_q, last_d, chan_q, chan_d, pick, idx;
    logic            edge_q, edge_d, take, xfer;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;
    assign evt  = enable & (rise | (mode & fall));
    assign xfer = (state_q == OFFER) & ev_ready;
    assign take = (|pend_q) & ((state_q == IDLE) | ev_ready);

    always_comb begin
        sync_d[0] = in;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    end

    // Scan downward so the nearest channel after last_q is assigned last and wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = CW'((int'(last_q) + k) % N);
            if (pend_q[idx]) pick = idx;
        end
    end

    // A slot handed to the output this cycle counts as free for a new event.
    always_comb begin
        take_mask = take ? N'(1) << pick : '0;
        free      = ~pend_q | take_mask;
        drop      = evt & ~free;
        pend_d    = evt | (pend_q & ~take_mask);
        for (int i = 0; i < N; i++) begin
            pend_edge_d[i] = (evt[i] & free[i]) ? rise[i] : pend_edge_q[i];
            pend_time_d[i] = (evt[i] & free[i]) ? ts_q : pend_time_q[i];
        end
        sum        = {1'b0, drop_cnt_q} + 9'($countones(drop));
        drop_cnt_d = clr_drop ? '0 : (sum[8] ? 8'hFF : sum[7:0]);
        ts_d       = ts_q + 1'b1;
    end

    always_comb begin
        chan_d = take ? pick : chan_q;
        edge_d = take ? pend_edge_q[pick] : edge_q;
        time_d = take ? pend_time_q[pick] : time_q;
        last_d = take ? pick : last_q;
    end

    always_comb begin
        state_d = take ? OFFER : (xfer ? IDLE : state_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < N; i++) pend_time_q[i] <= '0;
            prev_q      <= '0;
            pend_q      <= '0;
            pend_edge_q <= '0;
            ts_q        <= '0;
            drop_cnt_q  <= '0;
            last_q      <= CW'(N - 1);
            chan_q      <= '0;
            edge_q      <= 1'b0;
            time_q      <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
            for (int i = 0; i < N; i++) pend_time_q[i] <= pend_time_d[i];
            prev_q      <= s;
            pend_q      <= pend_d;
            pend_edge_q <= pend_edge_d;
            ts_q        <= ts_d;
            drop_cnt_q  <= drop_cnt_d;
            last_q      <= last_d;
            chan_q      <= chan_d;
            edge_q      <= edge_d;
            time_q      <= time_d;
        end
    end

    always_comb begin
        ev_valid = state_q == OFFER;
        ev_chan  = chan_q;
        ev_edge  = edge_q;
        ev_time  = time_q;
        drop_cnt = drop_cnt_q;
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: scoreboard bench; expected events are queued as
// stimulus is applied and compared against transfers seen on the event port.
module tb_edge_event_arbiter;
    localparam int N = 4, TS_W = 16, SS = 2;
    logic clk = 0, reset = 0, ev_ready = 0, clr_drop = 0;
    logic [N-1:0] in_l = '0, enable = '0, mode = '0;
    logic ev_valid, ev_edge;
    logic [1:0] ev_chan;
    logic [TS_W-1:0] ev_time;
    logic [7:0] drop_cnt;
    logic [31:0] cyc;
    typedef struct packed {
        logic [1:0]  chan;
        logic        edg;
        logic [15:0] tstamp;
        logic [31:0] cyc;
    } ev_t;
    ev_t exp_q[$], obs_q[$];
    ev_t e, o;
    int checks = 0, passed = 0;

    edge_event_arbiter #(.N(N), .TS_W(TS_W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .in(in_l), .enable(enable), .mode(mode),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
        .ev_edge(ev_edge), .ev_time(ev_time), .drop_cnt(drop_cnt),
        .clr_drop(clr_drop)
    );

    always #5 clk = ~clk;

    // Cycle counter mirrors the free-running timestamp: 0 in reset, +1 per edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // A valid&ready seen at the negedge transfers on the following posedge.
    always @(negedge clk)
        if (reset && ev_valid && ev_ready)
            obs_q.push_back(ev_t'{ev_chan, ev_edge, ev_time, cyc});

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(int ch, bit ed, int ts, int c);
        exp_q.push_back(ev_t'{2'(ch), ed, 16'(ts), 32'(c)});
    endtask

    task automatic test_reset;
        tick(3);
        checks++;
        if ({ev_valid, ev_chan, ev_edge, ev_time, drop_cnt} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {ev_valid, ev_chan, ev_edge, ev_time, drop_cnt});
        else passed++;
        reset = 1;
        tick(6);
        checks++;
        if (ev_valid !== 1'b0 || obs_q.size() != 0)
            $display("FAIL reset_idle: got valid=%b events=%0d expected 0/0", ev_valid, obs_q.size());
        else passed++;
    endtask

    task automatic test_single_rise;
        int t0;
        enable = '1; mode = '0; ev_ready = 1;
        in_l[2] = 1; t0 = cyc;
        expect_ev(2, 1, t0 + SS, t0 + SS + 2);
        tick(10);
        checks++;
        if (obs_q.size() != 1) $display("FAIL single_rise_count: got %0d expected 1", obs_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL single_rise_event: got %h expected %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        in_l[2] = 0;
        tick(10);
        checks++;
        if (obs_q.size() != 0 || drop_cnt !== 8'd0)
            $display("FAIL rise_only_fall: got events=%0d drops=%0d expected 0/0", obs_q.size(), drop_cnt);
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_both_edges;
        int t0, t1;
        mode = 4'b0010;
        in_l[1] = 1; t0 = cyc;
        expect_ev(1, 1, t0 + SS, t0 + SS + 2);
        tick(10);
        in_l[1] = 0; t1 = cyc;
        expect_ev(1, 0, t1 + SS, t1 + SS + 2);
        tick(10);
        checks++;
        if (obs_q.size() != 2) $display("FAIL both_edges_count: got %0d expected 2", obs_q.size());
        else passed++;
        if (obs_q.size() == 2) begin
            checks++;
            if (16'(obs_q[1].tstamp - obs_q[0].tstamp) !== 16'd10)
                $display("FAIL both_edges_delta: got %0d expected 10", 16'(obs_q[1].tstamp - obs_q[0].tstamp));
            else passed++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL both_edges_event: got %h expected %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_round_robin;
        int t0;
        mode = '0;
        reset = 0;
        tick(2);
        reset = 1;
        tick(2);
        in_l = 4'hF; t0 = cyc;
        for (int k = 0; k < N; k++) expect_ev(k, 1, t0 + SS, t0 + SS + 2 + k);
        tick(12);
        mode = 4'hF;
        in_l = 4'h0; t0 = cyc;
        for (int k = 0; k < N; k++) expect_ev(k, 0, t0 + SS, t0 + SS + 2 + k);
        tick(12);
        checks++;
        if (obs_q.size() != 2 * N) $display("FAIL round_robin_count: got %0d expected %0d", obs_q.size(), 2 * N);
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL round_robin_event: got %h expected %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure;
        int t0, t1, tr;
        ev_ready = 0; mode = 4'hF;
        in_l[0] = 1; t0 = cyc;
        tick(6);
        checks++;
        if ({ev_valid, ev_chan, ev_edge, ev_time} !== {1'b1, 2'd0, 1'b1, 16'(t0 + SS)})
            $display("FAIL bp_offer: got %h expected %h", {ev_valid, ev_chan, ev_edge, ev_time}, {1'b1, 2'd0, 1'b1, 16'(t0 + SS)});
        else passed++;
        in_l[0] = 0; t1 = cyc;
        tick(2);
        in_l[0] = 1;
        tick(6);
        checks++;
        if ({ev_valid, ev_chan, ev_edge, ev_time} !== {1'b1, 2'd0, 1'b1, 16'(t0 + SS)})
            $display("FAIL bp_stable: got %h expected %h", {ev_valid, ev_chan, ev_edge, ev_time}, {1'b1, 2'd0, 1'b1, 16'(t0 + SS)});
        else passed++;
        checks++;
        if (drop_cnt !== 8'd1) $display("FAIL bp_drop: got %0d expected 1", drop_cnt);
        else passed++;
        ev_ready = 1; tr = cyc;
        expect_ev(0, 1, t0 + SS, tr);
        expect_ev(0, 0, t1 + SS, tr + 1);
        tick(6);
        checks++;
        if (obs_q.size() != 2) $display("FAIL bp_count: got %0d expected 2", obs_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL bp_event: got %h expected %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation;
        ev_ready = 0; mode = 4'hF;
        for (int k = 0; k < 100; k++) begin
            in_l = ~in_l;
            tick(1);
        end
        checks++;
        if (drop_cnt !== 8'd255) $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
        else passed++;
        in_l = ~in_l; clr_drop = 1;
        tick(1);
        checks++;
        if (drop_cnt !== 8'd0) $display("FAIL drop_clear: got %0d expected 0", drop_cnt);
        else passed++;
        clr_drop = 0;
        tick(4);
    endtask

    task automatic test_async_reset;
        int t0;
        checks++;
        if (ev_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", ev_valid);
        else passed++;
        #3 reset = 0;
        #1;
        checks++;
        if ({ev_valid, ev_chan, ev_edge, ev_time, drop_cnt} !== '0)
            $display("FAIL areset_outputs: got %h expected 0", {ev_valid, ev_chan, ev_edge, ev_time, drop_cnt});
        else passed++;
        exp_q.delete(); obs_q.delete();
        in_l = 4'b0101;
        tick(2);
        reset = 1; ev_ready = 1; t0 = cyc;
        expect_ev(0, 1, t0 + SS, t0 + SS + 2);
        expect_ev(2, 1, t0 + SS, t0 + SS + 3);
        tick(10);
        checks++;
        if (obs_q.size() != 2) $display("FAIL areset_count: got %0d expected 2", obs_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL areset_event: got %h expected %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_both_edges();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
